pool_window_feeder: RTL and testbench

- Drives the pixel/clear interface of the max-pooling accumulator (12-bit pixel in, clear pulse, 12-bit running max out).
- Scans a row-major feature map held in a synchronous-read buffer and presents each KxK window's pixels to the accumulator.
- Captures each window's max and writes it to a row-major output buffer.
- Sits between the conv output RAM and the pooled-map RAM; launched by start, reports done.

---
 rtl/pool_window_feeder.sv | 162 ++++++++++++++++
 tb/tb_pool_window_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_feeder.sv
// Scans a row-major feature map in non-overlapping KxK windows. Each window's pixels go to a
// max-pool accumulator, and each window max goes to a row-major output buffer. Define
// `POOL_FEED_PAD_EN to keep partial edge windows (ceil dims); otherwise they are dropped.
module pool_window_feeder #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 2,
  parameter int PIX_W = 12,
  parameter int RD_AW = 10,
  parameter int WR_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [RD_AW-1:0] rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] pool_pix,
  output logic             pool_clr,
  input  logic [PIX_W-1:0] pool_result,
  output logic             wr_en,
  output logic [WR_AW-1:0] wr_addr,
  output logic [PIX_W-1:0] wr_data
);

`ifdef POOL_FEED_PAD_EN
  localparam int OUT_W = (IMG_W + K - 1) / K;
  localparam int OUT_H = (IMG_H + K - 1) / K;
`else
  localparam int OUT_W = IMG_W / K;
  localparam int OUT_H = IMG_H / K;
`endif

  localparam int KC_W = (K > 1) ? $clog2(K) : 1;
  localparam int OX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [KC_W-1:0] K_LAST  = KC_W'(K - 1);
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KC_W-1:0] kx_q, kx_d;
  logic [KC_W-1:0] ky_q, ky_d;
  logic [OX_W-1:0] ox_q, ox_d;
  logic [OY_W-1:0] oy_q, oy_d;
  logic            rd_vld_q;

  logic [31:0]      row_w;
  logic [31:0]      col_w;
  logic [RD_AW-1:0] rd_addr_w;
  logic [WR_AW-1:0] wr_addr_w;
  logic             elem_last;
  logic             elem_in_range;

  assign row_w     = 32'(oy_q) * 32'(K) + 32'(ky_q);
  assign col_w     = 32'(ox_q) * 32'(K) + 32'(kx_q);
  assign rd_addr_w = RD_AW'(row_w * 32'(IMG_W) + col_w);
  assign wr_addr_w = WR_AW'(32'(oy_q) * 32'(OUT_W) + 32'(ox_q));
  assign elem_last = (kx_q == K_LAST) && (ky_q == K_LAST);

`ifdef POOL_FEED_PAD_EN
  // Elements hanging off the map are skipped; with no read, the accumulator sees a 0.
  assign elem_in_range = (row_w < 32'(IMG_H)) && (col_w < 32'(IMG_W));
`else
  assign elem_in_range = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d  = state_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    pool_clr = 1'b0;
    wr_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR, S_READ: begin
        busy     = 1'b1;
        pool_clr = (state_q == S_CLR);
        rd_en    = elem_in_range;
        if (kx_q == K_LAST) begin
          kx_d = '0;
          ky_d = (ky_q == K_LAST) ? '0 : ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
        state_d = elem_last ? S_DRAIN : S_READ;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
        if (ox_q == OX_LAST) begin
          ox_d = '0;
          if (oy_q == OY_LAST) begin
            oy_d    = '0;
            state_d = S_DONE;
          end else begin
            oy_d    = oy_q + 1'b1;
            state_d = S_CLR;
          end
        end else begin
          ox_d    = ox_q + 1'b1;
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr  = rd_en ? rd_addr_w : '0;
  assign wr_addr  = wr_en ? wr_addr_w : '0;
  assign wr_data  = wr_en ? pool_result : '0;
  assign pool_pix = rd_vld_q ? rd_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kx_q     <= '0;
      ky_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      rd_vld_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: a 4x4 instance for timing, data, restart and reset cases, and a
// 5x5 instance for edge-window handling. Memory and accumulator models surround each instance.
module tb_pool_window_feeder;
  localparam int PIX_W = 12;
  localparam int RD_AW = 10;
  localparam int WR_AW = 8;

`ifdef POOL_FEED_PAD_EN
  localparam int B_WRITES = 9;
  int exp_b [9] = '{6, 8, 9, 16, 18, 19, 21, 23, 24};
`else
  localparam int B_WRITES = 4;
  int exp_b [4] = '{6, 8, 16, 18};
`endif

  typedef struct packed {
    logic [WR_AW-1:0] addr;
    logic [PIX_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic             start_a = 1'b0, busy_a, done_a, rd_en_a, pool_clr_a, wr_en_a;
  logic [RD_AW-1:0] rd_addr_a;
  logic [PIX_W-1:0] rd_data_a = '0, pool_pix_a, pool_result_a, wr_data_a;
  logic [WR_AW-1:0] wr_addr_a;

  logic             start_b = 1'b0, busy_b, done_b, rd_en_b, pool_clr_b, wr_en_b;
  logic [RD_AW-1:0] rd_addr_b;
  logic [PIX_W-1:0] rd_data_b = '0, pool_pix_b, pool_result_b, wr_data_b;
  logic [WR_AW-1:0] wr_addr_b;

  logic [PIX_W-1:0] mem_a [1024];
  logic [PIX_W-1:0] mem_b [1024];

  pool_window_feeder #(.IMG_W(4), .IMG_H(4), .K(2), .PIX_W(PIX_W), .RD_AW(RD_AW), .WR_AW(WR_AW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .pool_pix(pool_pix_a), .pool_clr(pool_clr_a), .pool_result(pool_result_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  pool_window_feeder #(.IMG_W(5), .IMG_H(5), .K(2), .PIX_W(PIX_W), .RD_AW(RD_AW), .WR_AW(WR_AW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .pool_pix(pool_pix_b), .pool_clr(pool_clr_b), .pool_result(pool_result_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  // Synchronous-read buffers and max accumulators (clear dominates compare).
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_result_a <= '0;
      pool_result_b <= '0;
    end else begin
      if (pool_clr_a) pool_result_a <= '0;
      else if (pool_pix_a > pool_result_a) pool_result_a <= pool_pix_a;
      if (pool_clr_b) pool_result_b <= '0;
      else if (pool_pix_b > pool_result_b) pool_result_b <= pool_pix_b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  wr_t q_a[$];
  wr_t q_b[$];
  int  t0_a = 0, t0_b = 0;
  int  wr_cnt_a, done_cnt_a, done_rel_a, first_wr_a, busy_first_a, busy_last_a, clr_cnt_a;
  int  wr_cnt_b, done_cnt_b, done_rel_b;
  bit  chk_rd_a = 1'b0;
  int  exp_rd [4] = '{0, 1, 4, 5};

  // Monitor: pops the scoreboard on every write and gathers timing observations.
  always @(negedge clk) begin
    int  rel;
    int  rel_b;
    wr_t e;
    rel   = cyc - t0_a;
    rel_b = cyc - t0_b;
    if (wr_en_a) begin
      wr_cnt_a++;
      if (first_wr_a < 0) first_wr_a = rel;
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_extra_write: got addr %0d data 0x%0h, want no write", wr_addr_a, wr_data_a);
      end else begin
        e = q_a.pop_front();
        check("a_wr_addr", 64'(wr_addr_a), 64'(e.addr));
        check("a_wr_data", 64'(wr_data_a), 64'(e.data));
      end
    end
    if (done_a) begin
      done_cnt_a++;
      done_rel_a = rel;
    end
    if (busy_a) begin
      if (busy_first_a < 0) busy_first_a = rel;
      busy_last_a = rel;
    end
    if (pool_clr_a) clr_cnt_a++;
    if (chk_rd_a && rel >= 1 && rel <= 5) begin
      check("a_rd_en_seq", 64'(rd_en_a), 64'(rel <= 4));
      if (rel <= 4) check("a_rd_addr_seq", 64'(rd_addr_a), 64'(exp_rd[rel-1]));
      check("a_pool_clr_seq", 64'(pool_clr_a), 64'(rel == 1));
    end

    if (wr_en_b) begin
      wr_cnt_b++;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_extra_write: got addr %0d data 0x%0h, want no write", wr_addr_b, wr_data_b);
      end else begin
        e = q_b.pop_front();
        check("b_wr_addr", 64'(wr_addr_b), 64'(e.addr));
        check("b_wr_data", 64'(wr_data_b), 64'(e.data));
      end
    end
    if (done_b) begin
      done_cnt_b++;
      done_rel_b = rel_b;
    end
    if (rd_en_b) check("b_rd_addr_in_map", 64'(rd_addr_b < 10'd25), 64'(1));
  end

  task automatic push_a(input int addr, input int data);
    q_a.push_back(wr_t'{addr: WR_AW'(addr), data: PIX_W'(data)});
  endtask

  task automatic load_ramp_a();
    for (int i = 0; i < 16; i++) mem_a[i] = PIX_W'(i);
  endtask

  task automatic push_ramp_a();
    push_a(0, 5);
    push_a(1, 7);
    push_a(2, 13);
    push_a(3, 15);
  endtask

  task automatic clear_stats_a();
    wr_cnt_a     = 0;
    done_cnt_a   = 0;
    done_rel_a   = -1;
    first_wr_a   = -1;
    busy_first_a = -1;
    busy_last_a  = -1;
    clr_cnt_a    = 0;
  endtask

  // Start is high in cycle 0; optional mid-run start pulse and reset pulse at given cycles.
  task automatic run_a(input bit chk_rd, input int restart_rel, input int rst_rel, input int len);
    clear_stats_a();
    @(posedge clk);
    #1;
    start_a  = 1'b1;
    t0_a     = cyc;
    chk_rd_a = chk_rd;
    for (int k = 1; k <= len; k++) begin
      @(posedge clk);
      #1;
      start_a = (k == restart_rel);
      if (k == rst_rel) begin
        rst = 1'b1;
        #1;
        check("rst_outputs_zero", 64'({busy_a, done_a, rd_en_a, rd_addr_a, pool_pix_a, pool_clr_a,
                                       wr_en_a, wr_addr_a, wr_data_a}), 64'(0));
      end
      if (k == rst_rel + 2) rst = 1'b0;
    end
    start_a  = 1'b0;
    chk_rd_a = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", 64'({busy_a, done_a, rd_en_a, rd_addr_a, pool_pix_a, pool_clr_a,
                                  wr_en_a, wr_addr_a, wr_data_a}), 64'(0));
    check("reset_outputs_b", 64'({busy_b, done_b, rd_en_b, rd_addr_b, pool_pix_b, pool_clr_b,
                                  wr_en_b, wr_addr_b, wr_data_b}), 64'(0));
    rst = 1'b0;

    // Ramp map: data, read order and cycle timing.
    load_ramp_a();
    push_ramp_a();
    run_a(1'b1, -100, -100, 32);
    check("ramp_first_wr_cycle", 64'(first_wr_a), 64'(6));
    check("ramp_done_cycle", 64'(done_rel_a), 64'(25));
    check("ramp_done_count", 64'(done_cnt_a), 64'(1));
    check("ramp_busy_first", 64'(busy_first_a), 64'(1));
    check("ramp_busy_last", 64'(busy_last_a), 64'(24));
    check("ramp_wr_count", 64'(wr_cnt_a), 64'(4));
    check("ramp_clr_count", 64'(clr_cnt_a), 64'(4));
    check("ramp_queue_empty", 64'(q_a.size()), 64'(0));

    // All 0xFFF with one zero per window, in a different position each time.
    for (int i = 0; i < 16; i++) mem_a[i] = 12'hFFF;
    mem_a[0]  = '0;
    mem_a[3]  = '0;
    mem_a[12] = '0;
    mem_a[15] = '0;
    for (int w = 0; w < 4; w++) push_a(w, 12'hFFF);
    run_a(1'b0, -100, -100, 32);
    check("fff_wr_count", 64'(wr_cnt_a), 64'(4));
    check("fff_queue_empty", 64'(q_a.size()), 64'(0));

    // Each window's max sits in its last element.
    for (int i = 0; i < 16; i++) mem_a[i] = 12'h001;
    mem_a[5]  = 12'h800;
    mem_a[7]  = 12'h801;
    mem_a[13] = 12'h802;
    mem_a[15] = 12'hFFF;
    push_a(0, 12'h800);
    push_a(1, 12'h801);
    push_a(2, 12'h802);
    push_a(3, 12'hFFF);
    run_a(1'b0, -100, -100, 32);
    check("last_elem_wr_count", 64'(wr_cnt_a), 64'(4));
    check("last_elem_queue_empty", 64'(q_a.size()), 64'(0));

    // Start pulsed again at cycle 10 while busy.
    load_ramp_a();
    push_ramp_a();
    run_a(1'b0, 10, -100, 32);
    check("restart_wr_count", 64'(wr_cnt_a), 64'(4));
    check("restart_done_cycle", 64'(done_rel_a), 64'(25));
    check("restart_done_count", 64'(done_cnt_a), 64'(1));

    // Reset at cycle 9 aborts after the first write.
    push_a(0, 5);
    run_a(1'b0, -100, 9, 40);
    check("abort_wr_count", 64'(wr_cnt_a), 64'(1));
    check("abort_done_count", 64'(done_cnt_a), 64'(0));
    check("abort_busy_last", 64'(busy_last_a), 64'(8));
    check("abort_queue_empty", 64'(q_a.size()), 64'(0));

    // Full run after the abort.
    push_ramp_a();
    run_a(1'b0, -100, -100, 32);
    check("post_abort_wr_count", 64'(wr_cnt_a), 64'(4));
    check("post_abort_done_cycle", 64'(done_rel_a), 64'(25));
    check("post_abort_queue_empty", 64'(q_a.size()), 64'(0));

    // 5x5 map, K=2: partial edge windows kept or dropped depending on the build.
    for (int i = 0; i < 25; i++) mem_b[i] = PIX_W'(i);
    for (int w = 0; w < B_WRITES; w++)
      q_b.push_back(wr_t'{addr: WR_AW'(w), data: PIX_W'(exp_b[w])});
    wr_cnt_b   = 0;
    done_cnt_b = 0;
    done_rel_b = -1;
    @(posedge clk);
    #1;
    start_b = 1'b1;
    t0_b    = cyc;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    check("b_wr_count", 64'(wr_cnt_b), 64'(B_WRITES));
    check("b_done_count", 64'(done_cnt_b), 64'(1));
    check("b_done_cycle", 64'(done_rel_b), 64'(B_WRITES * 6 + 1));
    check("b_queue_empty", 64'(q_b.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
